// File: rtl/bool_array_fill.sv
// rtl/bool_array_fill.sv - counted loop that clears/sets/toggles/copies one bit of a boolean array per iteration
//
// Purpose:
//   On an accepted run request, walks a loop of i_count iterations. Each
//   iteration spends one cycle in BODY0, where one bit of the field array is
//   written, and one cycle in BODY1, which is reserved. The bit index wraps
//   modulo N_BITS, so counts larger than the array revisit earlier bits.
//   Busy lasts 3*count+3 enabled cycles.
//
// Optional feature:
//   BOOL_ARRAY_FILL_DONE_PULSE_EN adds o_run_done. It is a one-cycle
//   registered pulse that coincides with busy falling.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset (overrides ce)
//   ce          in   clock enable; all state holds while low
//   i_run_req   in   start request, only sampled in IDLE
//   i_count     in   iteration count, latched at accept
//   i_mode      in   0=clear 1=set 2=toggle 3=copy i_val, latched at accept
//   i_val       in   copy value for mode 3, latched at accept
//   o_run_busy  out  high from accept+1 until the loop is done
//   o_fld_a     out  boolean field array register
//   o_run_done  out  done pulse (only with BOOL_ARRAY_FILL_DONE_PULSE_EN)

module bool_array_fill #(
  parameter int                N_BITS    = 8,
  parameter int                CNT_W     = 8,
  parameter logic [N_BITS-1:0] RESET_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              i_run_req,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [1:0]        i_mode,
  input  logic              i_val,
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
  output logic              o_run_done,
`endif
  output logic              o_run_busy,
  output logic [N_BITS-1:0] o_fld_a
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_BODY0 = 3'd3,
    S_BODY1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic [N_BITS-1:0]   r_fld;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_mode;
  logic                r_val;
  logic [CNT_W-1:0]    r_i;
  logic [IDX_W-1:0]    r_idx;
  logic                w_new_bit;

  // Value written to the addressed bit in BODY0, from the latched mode.
  always_comb begin
    w_new_bit = 1'b0;
    case (r_mode)
      2'd0:    w_new_bit = 1'b0;
      2'd1:    w_new_bit = 1'b1;
      2'd2:    w_new_bit = ~r_fld[r_idx];
      default: w_new_bit = r_val;
    endcase
  end

`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
  logic r_done;

  // The pulse is set on the edge leaving DONE. It clears on the next enabled
  // edge, so a ce-low stretch holds it instead of re-pulsing.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done <= 1'b0;
    end else if (ce) begin
      r_done <= (r_state == S_DONE);
    end
  end

  assign o_run_done = r_done;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_fld   <= RESET_VAL;
      r_cnt   <= '0;
      r_mode  <= 2'd0;
      r_val   <= 1'b0;
      r_i     <= '0;
      r_idx   <= '0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (i_run_req) begin
            r_cnt   <= i_count;
            r_mode  <= i_mode;
            r_val   <= i_val;
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_i     <= '0;
          r_idx   <= '0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          // The counter stops at r_cnt, which fits in CNT_W, so it cannot wrap.
          if (r_i < r_cnt) begin
            r_state <= S_BODY0;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_BODY0: begin
          r_fld[r_idx] <= w_new_bit;
          r_i          <= r_i + 1'b1;
          r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          r_state      <= S_BODY1;
        end
        S_BODY1: begin
          r_state <= S_CHECK;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_run_busy = r_busy;
  assign o_fld_a    = r_fld;

endmodule

// File: tb/tb_bool_array_fill.sv
// tb/tb_bool_array_fill.sv - self-checking bench for bool_array_fill against a loop-level reference model

module tb_bool_array_fill;

  localparam int N_BITS = 8;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              ce = 1'b1;
  logic              i_run_req = 1'b0;
  logic [CNT_W-1:0]  i_count = '0;
  logic [1:0]        i_mode = 2'd0;
  logic              i_val = 1'b0;
  logic              o_run_busy;
  logic [N_BITS-1:0] o_fld_a;
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
  logic              o_run_done;
`endif

  int checks = 0;
  int errors = 0;
  logic [N_BITS-1:0] m_fld;

  bool_array_fill #(.N_BITS(N_BITS), .CNT_W(CNT_W), .RESET_VAL('0)) dut (
    .clock(clock),
    .reset(reset),
    .ce(ce),
    .i_run_req(i_run_req),
    .i_count(i_count),
    .i_mode(i_mode),
    .i_val(i_val),
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
    .o_run_done(o_run_done),
`endif
    .o_run_busy(o_run_busy),
    .o_fld_a(o_fld_a)
  );

  always #5 clock = ~clock;

  // Reference: iteration k touches bit k mod N_BITS.
  function automatic logic [N_BITS-1:0] model(input logic [N_BITS-1:0] fld, input int cnt,
                                              input int mode, input logic val);
    logic [N_BITS-1:0] f;
    f = fld;
    for (int k = 0; k < cnt; k++) begin
      case (mode)
        0: f[k % N_BITS] = 1'b0;
        1: f[k % N_BITS] = 1'b1;
        2: f[k % N_BITS] = ~f[k % N_BITS];
        default: f[k % N_BITS] = val;
      endcase
    end
    return f;
  endfunction

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; ce = 1'b1; i_run_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_fld = '0;
  endtask

  // Issues one request and counts busy samples. A stall sets ce low for
  // stall_len cycles starting at busy sample stall_at. Noise pulses the
  // request and scrambles the inputs at busy sample noise_at.
  task automatic run_op(input string name, input int cnt, input int mode, input logic val,
                        input int stall_at, input int stall_len, input int noise_at);
    int cyc;
    int limit;
    int done_early;
    logic [N_BITS-1:0] exp_fld;
    exp_fld = model(m_fld, cnt, mode, val);
    limit = 3 * cnt + 3 + stall_len + 10;
    i_count = CNT_W'(cnt); i_mode = 2'(mode); i_val = val; i_run_req = 1'b1;
    @(posedge clock); #1;
    i_run_req = 1'b0;
    cyc = 0;
    done_early = 0;
    while (o_run_busy && cyc < limit) begin
      cyc++;
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
      if (o_run_done) done_early++;
`endif
      ce = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      if (cyc == noise_at) begin
        i_run_req = 1'b1; i_mode = ~2'(mode); i_val = ~val; i_count = CNT_W'(cnt + 5);
      end
      if (cyc == noise_at + 1) i_run_req = 1'b0;
      @(posedge clock); #1;
    end
    ce = 1'b1; i_run_req = 1'b0;
    checks++;
    if (cyc !== 3 * cnt + 3 + stall_len) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, 3 * cnt + 3 + stall_len);
    end
    checks++;
    if (o_fld_a !== exp_fld) begin
      errors++;
      $display("FAIL %s field: got %h expected %h", name, o_fld_a, exp_fld);
    end
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
    checks++;
    if (done_early !== 0 || o_run_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: early=%0d at_fall=%b expected early=0 at_fall=1",
               name, done_early, o_run_done);
    end
`endif
    m_fld = exp_fld;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_run_busy !== 1'b0 || o_fld_a !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b fld=%h expected busy=0 fld=00", o_run_busy, o_fld_a);
    end
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
    checks++;
    if (o_run_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", o_run_done);
    end
`endif
  endtask

  task automatic test_set();
    do_reset();
    run_op("set10", 10, 1, 1'b0, -1, 0, -1);
    checks++;
    if (o_fld_a !== 8'hFF) begin
      errors++;
      $display("FAIL set10_const: got %h expected ff", o_fld_a);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    run_op("toggle10", 10, 2, 1'b0, -1, 0, -1);
    checks++;
    if (o_fld_a !== 8'hFC) begin
      errors++;
      $display("FAIL toggle10_const: got %h expected fc", o_fld_a);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    run_op("zero", 0, 1, 1'b0, -1, 0, -1);
    run_op("copy3", 3, 3, 1'b1, -1, 0, -1);
    checks++;
    if (o_fld_a !== 8'h07) begin
      errors++;
      $display("FAIL copy3_const: got %h expected 07", o_fld_a);
    end
  endtask

  task automatic test_ce_hold();
    do_reset();
    // Busy sample 3 is the first BODY0.
    run_op("ce_hold", 10, 1, 1'b0, 3, 5, 12);
    repeat (4) begin
      @(posedge clock); #1;
      checks++;
      if (o_run_busy !== 1'b0) begin
        errors++;
        $display("FAIL ce_hold_no_rerun: busy=%b expected 0", o_run_busy);
      end
    end
    checks++;
    if (o_fld_a !== 8'hFF) begin
      errors++;
      $display("FAIL ce_hold_field_after: got %h expected ff", o_fld_a);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    do_reset();
    i_count = 8'd10; i_mode = 2'd1; i_val = 1'b0; i_run_req = 1'b1;
    @(posedge clock); #1;
    i_run_req = 1'b0;
    cyc = 1;
    while (cyc < 12 && o_run_busy) begin
      @(posedge clock); #1;
      cyc++;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (o_run_busy !== 1'b0 || o_fld_a !== '0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b fld=%h expected busy=0 fld=00", o_run_busy, o_fld_a);
    end
    m_fld = '0;
    run_op("after_abort", 5, 3, 1'b1, -1, 0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      run_op("random", int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), -1, 0, -1);
    end
  endtask

  task automatic test_max_count();
    run_op("max_toggle", 255, 2, 1'b0, -1, 0, -1);
  endtask

`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
  task automatic test_done_pulse();
    do_reset();
    run_op("done2", 2, 1, 1'b0, -1, 0, -1);
    @(posedge clock); #1;
    checks++;
    if (o_run_done !== 1'b0) begin
      errors++;
      $display("FAIL done2_single: got %b expected 0", o_run_done);
    end
  endtask
`endif

  initial begin
    m_fld = '0;
    test_reset();
    test_set();
    test_toggle();
    test_zero_count();
    test_ce_hold();
    test_reset_abort();
    test_random();
    test_max_count();
`ifdef BOOL_ARRAY_FILL_DONE_PULSE_EN
    test_done_pulse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
